// File: rtl/predecode_queue.sv
// Fetch-to-decode instruction queue; tags each instruction on entry and presents up to OUT_W head slots.
// Latency: push visible on out_* one cycle after the write edge, no bypass; outputs depend on registered state only.
// Backpressure: push_ready drops when fewer than IN_W entries are free; a push while not ready is dropped.
module predecode_queue #(
    parameter int DEPTH = 8,
    parameter int IN_W  = 2,
    parameter int OUT_W = 2
) (
    input  logic                 clk,
    input  logic                 resetn,
    input  logic                 flush,
    input  logic                 push_valid,
    input  logic [1:0]           push_cnt,
    input  logic [IN_W*32-1:0]   push_instr,
    input  logic [31:0]          push_pc,
    output logic                 push_ready,
    output logic [OUT_W-1:0]     out_valid,
    output logic [OUT_W*32-1:0]  out_instr,
    output logic [OUT_W*32-1:0]  out_pc,
    output logic [OUT_W*4-1:0]   out_tag,
    input  logic [1:0]           pop_cnt
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [31:0]   instr_q [DEPTH];
    logic [31:0]   instr_d [DEPTH];
    logic [31:0]   pc_q    [DEPTH];
    logic [31:0]   pc_d    [DEPTH];
    logic [3:0]    tag_q   [DEPTH];
    logic [3:0]    tag_d   [DEPTH];
    logic [PW-1:0] head_q, head_d, tail_q, tail_d;
    logic [CW-1:0] count_q, count_d;

    logic [PW-1:0] rd_idx [OUT_W];
    logic          head_single;
    logic [1:0]    n_valid, pop_n, push_lim, push_n;

    // Tag layout: {is_eret, is_break, is_syscall, is_branch}
    function automatic logic [3:0] predecode(input logic [31:0] i);
        logic [3:0] t;
        logic [5:0] op;
        logic [5:0] fn;
        logic       special;
        op      = i[31:26];
        fn      = i[5:0];
        special = (op == 6'b000000);
        t[0] = ((op >= 6'd1) && (op <= 6'd7)) || (special && ((fn == 6'b001000) || (fn == 6'b001001)));
        t[1] = special && (fn == 6'b001100);
        t[2] = special && (fn == 6'b001101);
        t[3] = (i == 32'h42000018);
        return t;
    endfunction

    assign push_ready = (count_q <= CW'(DEPTH - IN_W));

    always_comb begin
        out_valid = '0;
        out_instr = '0;
        out_pc    = '0;
        out_tag   = '0;
        for (int k = 0; k < OUT_W; k++) begin
            rd_idx[k] = head_q + PW'(k);
            out_instr[32*k +: 32] = instr_q[rd_idx[k]];
            out_pc[32*k +: 32]    = pc_q[rd_idx[k]];
            out_tag[4*k +: 4]     = tag_q[rd_idx[k]];
        end
        // Exception-class instructions issue alone, whichever slot they sit in
        head_single  = |tag_q[rd_idx[0]][3:1];
        out_valid[0] = (count_q != '0);
        for (int k = 1; k < OUT_W; k++) begin
            out_valid[k] = (count_q > CW'(k)) && !head_single && !(|tag_q[rd_idx[k]][3:1]);
        end
    end

    always_comb begin
        n_valid = '0;
        for (int k = 0; k < OUT_W; k++) begin
            n_valid = n_valid + 2'(out_valid[k]);
        end
        pop_n    = (pop_cnt < n_valid) ? pop_cnt : n_valid;
        push_lim = (push_cnt > 2'(IN_W)) ? 2'(IN_W) : push_cnt;
        push_n   = (push_valid && push_ready) ? push_lim : 2'd0;
    end

    always_comb begin
        instr_d = instr_q;
        pc_d    = pc_q;
        tag_d   = tag_q;
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        if (flush) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end else begin
            for (int k = 0; k < IN_W; k++) begin
                if (2'(k) < push_n) begin
                    instr_d[tail_q + PW'(k)] = push_instr[32*k +: 32];
                    pc_d[tail_q + PW'(k)]    = push_pc + 32'(4 * k);
                    tag_d[tail_q + PW'(k)]   = predecode(push_instr[32*k +: 32]);
                end
            end
            tail_d  = tail_q + PW'(push_n);
            head_d  = head_q + PW'(pop_n);
            count_d = count_q + CW'(push_n) - CW'(pop_n);
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            for (int e = 0; e < DEPTH; e++) begin
                instr_q[e] <= '0;
                pc_q[e]    <= '0;
                tag_q[e]   <= '0;
            end
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            instr_q <= instr_d;
            pc_q    <= pc_d;
            tag_q   <= tag_d;
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end
endmodule

// File: tb/tb_predecode_queue.sv
// Directed bench for predecode_queue: table of single-cycle vectors plus sequences for reset, flush, clamp and wrap.
module tb_predecode_queue;
    localparam logic [31:0] ADDU = 32'h00851021;
    localparam logic [31:0] LW   = 32'h8C820000;
    localparam logic [31:0] SYSC = 32'h0000000C;
    localparam logic [31:0] BRK  = 32'h0000000D;
    localparam logic [31:0] ERET = 32'h42000018;
    localparam logic [31:0] BEQ  = 32'h10220003;
    localparam logic [31:0] NOP  = 32'h00000000;
    localparam logic [31:0] JR   = 32'h03E00008;
    localparam logic [31:0] JAL  = 32'h0C000000;
    localparam logic [31:0] BGEZ = 32'h04010005;
    localparam logic [31:0] JMP  = 32'h08000000;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        flush = 1'b0;
    logic        push_valid = 1'b0;
    logic [1:0]  push_cnt = 2'd0;
    logic [63:0] push_instr = '0;
    logic [31:0] push_pc = '0;
    logic [1:0]  pop_cnt = 2'd0;
    logic        push_ready;
    logic [1:0]  out_valid;
    logic [63:0] out_instr;
    logic [63:0] out_pc;
    logic [7:0]  out_tag;

    int checks = 0;
    int errors = 0;

    predecode_queue #(.DEPTH(8), .IN_W(2), .OUT_W(2)) dut (
        .clk(clk), .resetn(resetn), .flush(flush),
        .push_valid(push_valid), .push_cnt(push_cnt), .push_instr(push_instr), .push_pc(push_pc),
        .push_ready(push_ready), .out_valid(out_valid), .out_instr(out_instr), .out_pc(out_pc),
        .out_tag(out_tag), .pop_cnt(pop_cnt)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL timeout: bench did not finish within time limit");
        $fatal(1, "timeout");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic f, input logic pv, input logic [1:0] pn, input logic [31:0] i0,
                         input logic [31:0] i1, input logic [31:0] pc, input logic [1:0] pop);
        @(negedge clk);
        flush      = f;
        push_valid = pv;
        push_cnt   = pn;
        push_instr = {i1, i0};
        push_pc    = pc;
        pop_cnt    = pop;
    endtask

    task automatic apply(input logic f, input logic pv, input logic [1:0] pn, input logic [31:0] i0,
                         input logic [31:0] i1, input logic [31:0] pc, input logic [1:0] pop);
        drive(f, pv, pn, i0, i1, pc, pop);
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic        fl;
        logic        pv;
        logic [1:0]  pn;
        logic [31:0] i0;
        logic [31:0] i1;
        logic [31:0] pc;
        logic [1:0]  pop;
        logic [1:0]  ev;
        logic        er;
        logic [3:0]  ec;
        logic [31:0] epc0;
        logic [31:0] epc1;
        logic [31:0] ei0;
        logic [3:0]  et0;
        logic [3:0]  et1;
    } vec_t;

    vec_t tbl [11];

    // Scoreboard for the full/wrap phase
    logic [31:0] q_pc[$];
    logic [31:0] next_pc;

    task automatic mstep(input logic pv, input logic [1:0] pop);
        bit       m_ready;
        int       nv;
        int       npop;
        m_ready = (q_pc.size() <= 6);
        nv      = (q_pc.size() >= 2) ? 2 : q_pc.size();
        npop    = (int'(pop) < nv) ? int'(pop) : nv;
        apply(1'b0, pv, 2'd2, NOP, NOP, next_pc, pop);
        for (int i = 0; i < npop; i++) void'(q_pc.pop_front());
        if (pv && m_ready) begin
            q_pc.push_back(next_pc);
            q_pc.push_back(next_pc + 32'd4);
        end
        if (pv) next_pc = next_pc + 32'd8;
        chk("wrap_count", 32'(dut.count_q), 32'(q_pc.size()));
        chk("wrap_valid", 32'(out_valid), {30'd0, q_pc.size() >= 2, q_pc.size() >= 1});
        chk("wrap_ready", 32'(push_ready), 32'(q_pc.size() <= 6));
        if (q_pc.size() >= 1) chk("wrap_pc0", out_pc[31:0], q_pc[0]);
        if (q_pc.size() >= 2) chk("wrap_pc1", out_pc[63:32], q_pc[1]);
    endtask

    initial begin
        tbl[0]  = '{1'b0, 1'b1, 2'd2, ADDU, LW,   32'hBFC00000, 2'd0, 2'b11, 1'b1, 4'd2, 32'hBFC00000, 32'hBFC00004, ADDU, 4'b0000, 4'b0000};
        tbl[1]  = '{1'b0, 1'b1, 2'd2, SYSC, ADDU, 32'h00000100, 2'd2, 2'b01, 1'b1, 4'd2, 32'h00000100, 32'h00000104, SYSC, 4'b0010, 4'b0000};
        tbl[2]  = '{1'b0, 1'b0, 2'd0, NOP,  NOP,  32'h00000000, 2'd2, 2'b01, 1'b1, 4'd1, 32'h00000104, 32'h00000000, ADDU, 4'b0000, 4'b0000};
        tbl[3]  = '{1'b0, 1'b1, 2'd2, BEQ,  NOP,  32'h00000200, 2'd1, 2'b11, 1'b1, 4'd2, 32'h00000200, 32'h00000204, BEQ,  4'b0001, 4'b0000};
        tbl[4]  = '{1'b0, 1'b1, 2'd2, NOP,  ERET, 32'h00000300, 2'd2, 2'b01, 1'b1, 4'd2, 32'h00000300, 32'h00000304, NOP,  4'b0000, 4'b1000};
        tbl[5]  = '{1'b0, 1'b1, 2'd1, JR,   NOP,  32'h00000400, 2'd1, 2'b01, 1'b1, 4'd2, 32'h00000304, 32'h00000400, ERET, 4'b1000, 4'b0001};
        tbl[6]  = '{1'b0, 1'b1, 2'd1, BRK,  NOP,  32'h00000500, 2'd1, 2'b01, 1'b1, 4'd2, 32'h00000400, 32'h00000500, JR,   4'b0001, 4'b0100};
        tbl[7]  = '{1'b0, 1'b1, 2'd1, JAL,  NOP,  32'h00000600, 2'd1, 2'b01, 1'b1, 4'd2, 32'h00000500, 32'h00000600, BRK,  4'b0100, 4'b0001};
        tbl[8]  = '{1'b0, 1'b0, 2'd0, NOP,  NOP,  32'h00000000, 2'd2, 2'b01, 1'b1, 4'd1, 32'h00000600, 32'h00000000, JAL,  4'b0001, 4'b0000};
        tbl[9]  = '{1'b0, 1'b1, 2'd2, BGEZ, JMP,  32'h00000700, 2'd1, 2'b11, 1'b1, 4'd2, 32'h00000700, 32'h00000704, BGEZ, 4'b0001, 4'b0001};
        tbl[10] = '{1'b0, 1'b0, 2'd0, NOP,  NOP,  32'h00000000, 2'd2, 2'b00, 1'b1, 4'd0, 32'h00000000, 32'h00000000, NOP,  4'b0000, 4'b0000};

        // Reset state
        #12;
        chk("rst_valid", 32'(out_valid), 32'd0);
        chk("rst_ready", 32'(push_ready), 32'd1);
        chk("rst_instr", out_instr[31:0], 32'd0);
        chk("rst_pc", out_pc[31:0], 32'd0);
        chk("rst_tag", 32'(out_tag), 32'd0);
        @(negedge clk);
        resetn = 1'b1;

        // Reset asserted mid-stream with five entries held
        apply(1'b0, 1'b1, 2'd2, ADDU, ADDU, 32'h00000010, 2'd0);
        apply(1'b0, 1'b1, 2'd2, ADDU, ADDU, 32'h00000020, 2'd0);
        apply(1'b0, 1'b1, 2'd1, ADDU, ADDU, 32'h00000030, 2'd0);
        chk("pre_rst_count", 32'(dut.count_q), 32'd5);
        push_valid = 1'b0;
        resetn = 1'b0;
        #1;
        chk("mid_rst_valid", 32'(out_valid), 32'd0);
        chk("mid_rst_ready", 32'(push_ready), 32'd1);
        @(negedge clk);
        resetn = 1'b1;
        @(posedge clk);
        #1;
        chk("post_rst_count", 32'(dut.count_q), 32'd0);

        // Table-driven single-cycle vectors
        for (int r = 0; r < 11; r++) begin
            apply(tbl[r].fl, tbl[r].pv, tbl[r].pn, tbl[r].i0, tbl[r].i1, tbl[r].pc, tbl[r].pop);
            chk($sformatf("v%0d_valid", r), 32'(out_valid), 32'(tbl[r].ev));
            chk($sformatf("v%0d_ready", r), 32'(push_ready), 32'(tbl[r].er));
            chk($sformatf("v%0d_count", r), 32'(dut.count_q), 32'(tbl[r].ec));
            if (tbl[r].ev[0]) begin
                chk($sformatf("v%0d_pc0", r), out_pc[31:0], tbl[r].epc0);
                chk($sformatf("v%0d_instr0", r), out_instr[31:0], tbl[r].ei0);
                chk($sformatf("v%0d_tag0", r), 32'(out_tag[3:0]), 32'(tbl[r].et0));
            end
            if (tbl[r].ec >= 4'd2) begin
                chk($sformatf("v%0d_pc1", r), out_pc[63:32], tbl[r].epc1);
                chk($sformatf("v%0d_tag1", r), 32'(out_tag[7:4]), 32'(tbl[r].et1));
            end
        end

        // Flush colliding with push and pop
        apply(1'b0, 1'b1, 2'd2, ADDU, ADDU, 32'h00000800, 2'd0);
        apply(1'b0, 1'b1, 2'd2, ADDU, ADDU, 32'h00000810, 2'd0);
        chk("fl_pre_count", 32'(dut.count_q), 32'd4);
        apply(1'b1, 1'b1, 2'd2, LW, LW, 32'h00000820, 2'd2);
        chk("fl_count", 32'(dut.count_q), 32'd0);
        chk("fl_valid", 32'(out_valid), 32'd0);
        chk("fl_head", 32'(dut.head_q), 32'd0);
        chk("fl_tail", 32'(dut.tail_q), 32'd0);
        drive(1'b0, 1'b1, 2'd1, LW, NOP, 32'h00000900, 2'd0);
        #1;
        chk("fl_no_bypass", 32'(out_valid), 32'd0);
        @(posedge clk);
        #1;
        chk("fl_push_valid", 32'(out_valid), 32'd1);
        chk("fl_push_pc", out_pc[31:0], 32'h00000900);
        chk("fl_push_instr", out_instr[31:0], LW);

        // Over-pop clamp with one entry held
        apply(1'b0, 1'b0, 2'd0, NOP, NOP, 32'd0, 2'd2);
        chk("clamp_count", 32'(dut.count_q), 32'd0);
        chk("clamp_head", 32'(dut.head_q), 32'd1);
        chk("clamp_valid", 32'(out_valid), 32'd0);

        // Fill, overfill and wrap with a PC scoreboard
        next_pc = 32'h00001000;
        for (int c = 0; c < 3; c++) mstep(1'b1, 2'd0);
        chk("fill6_count", 32'(dut.count_q), 32'd6);
        chk("fill6_ready", 32'(push_ready), 32'd1);
        mstep(1'b1, 2'd0);
        chk("full_count", 32'(dut.count_q), 32'd8);
        chk("full_ready", 32'(push_ready), 32'd0);
        mstep(1'b1, 2'd0);
        chk("drop_count", 32'(dut.count_q), 32'd8);
        chk("drop_pc0", out_pc[31:0], 32'h00001000);
        for (int c = 0; c < 8; c++) mstep(1'b1, 2'd2);
        for (int c = 0; c < 4; c++) mstep(1'b0, 2'd2);
        chk("drain_count", 32'(dut.count_q), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
